// File: rtl/client_req_queue.sv
// Request queue feeding an arbiter client port: requests are buffered in a circular FIFO and
// issued one at a time, and each acknowledge payload is captured as a one-cycle response.
module client_req_queue #(
  parameter int REQ_DATA_WIDTH = 8,
  parameter int ACK_DATA_WIDTH = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int GAP_CYCLES     = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [REQ_DATA_WIDTH-1:0]     push_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          client_req,
  output logic [REQ_DATA_WIDTH-1:0]     client_data_req,
  input  logic                          client_ack,
  input  logic [ACK_DATA_WIDTH-1:0]     client_data_ack,
  output logic                          rsp_valid,
  output logic [ACK_DATA_WIDTH-1:0]     rsp_data,
  output logic [1:0]                    fsm_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [GW-1:0] GAP_ONE = GW'(1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t                    state_q;
  logic [REQ_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]             count_q, count_d;
  logic [GW-1:0]             gap_cnt_q;
  logic                      overflow_q, client_req_q, rsp_valid_q;
  logic [REQ_DATA_WIDTH-1:0] client_data_req_q;
  logic [ACK_DATA_WIDTH-1:0] rsp_data_q;
  logic                      pop, push_ok;

  // Client handshake: client_req rises with client_data_req and both hold until an edge
  // samples client_ack = 1 in REQ; that edge pops the head and captures client_data_ack.
  // Acks seen outside REQ are ignored.
  assign pop     = (state_q == S_REQ) && client_ack;
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign push_ok = push && (!full || pop);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push_ok && pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Storage carries no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (!rst_n && push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q           <= S_IDLE;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      gap_cnt_q         <= '0;
      overflow_q        <= 1'b0;
      client_req_q      <= 1'b0;
      client_data_req_q <= '0;
      rsp_valid_q       <= 1'b0;
      rsp_data_q        <= '0;
    end else begin
      count_q     <= count_d;
      rsp_valid_q <= 1'b0;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      if (push && !push_ok) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            client_req_q      <= 1'b1;
            client_data_req_q <= mem_q[rd_ptr_q];
            state_q           <= S_REQ;
          end
        end
        S_REQ: begin
          if (client_ack) begin
            client_req_q <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_data_q   <= client_data_ack;
            gap_cnt_q    <= GAP_LOAD;
            state_q      <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign count           = count_q;
  assign overflow        = overflow_q;
  assign client_req      = client_req_q;
  assign client_data_req = client_data_req_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign fsm_state_o     = state_q;

endmodule

// File: tb/tb_client_req_queue.sv
// Bench for client_req_queue: vector table, directed corner sequences, then random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_client_req_queue;

  localparam int DEPTH = 4;
  localparam int GAP   = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       push = 1'b0;
  logic [7:0] push_data = '0;
  logic       client_ack = 1'b0;
  logic [7:0] client_data_ack = '0;
  logic       full, overflow, client_req, rsp_valid;
  logic [2:0] count;
  logic [7:0] client_data_req, rsp_data;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  client_req_queue #(
    .REQ_DATA_WIDTH(8), .ACK_DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data), .full(full),
    .count(count), .overflow(overflow), .client_req(client_req),
    .client_data_req(client_data_req), .client_ack(client_ack),
    .client_data_ack(client_data_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .fsm_state_o(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=still_running exp=finished");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic p, input logic [7:0] d,
                       input logic a, input logic [7:0] ad);
    rst_n = r; push = p; push_data = d; client_ack = a; client_data_ack = ad;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    else n_pass++;
  endtask

  // reference model: request queue plus a cooldown count of edges before the next issue
  logic [7:0] mq[$];
  bit         m_req, m_rv, m_ovf;
  logic [7:0] m_data, m_rd;
  int         m_cool;

  task automatic model_step(input logic r, input logic p, input logic [7:0] d,
                            input logic a, input logic [7:0] ad);
    int  pre;
    bit  popped;
    if (r) begin
      mq.delete(); m_req = 0; m_rv = 0; m_ovf = 0; m_data = '0; m_rd = '0; m_cool = 0;
    end else begin
      pre    = mq.size();
      popped = m_req && a;
      m_rv   = 0;
      if (popped) begin
        void'(mq.pop_front());
        m_req = 0; m_rv = 1; m_rd = ad; m_cool = GAP;
      end else if (!m_req) begin
        if (m_cool > 0) m_cool--;
        else if (pre != 0) begin m_req = 1; m_data = mq[0]; end
      end
      if (p) begin
        if (pre < DEPTH || popped) mq.push_back(d);
        else m_ovf = 1;
      end
    end
  endtask

  typedef struct {
    logic       rst, push;
    logic [7:0] pd;
    logic       ack;
    logic [7:0] ad;
    logic       e_req;
    logic [7:0] e_data;
    logic [2:0] e_cnt;
    logic       e_rv;
    logic [7:0] e_rd;
  } vec_t;

  vec_t       tbl[10];
  logic [7:0] exp_q[$];

  initial begin
    int  low;
    bit  got_req;
    int  pp;
    logic [7:0] e;
    logic r, p, a;
    logic [7:0] pd, ad;

    // single transfer, then spurious acks in GAP and IDLE, then a push alongside an idle ack
    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00, 3'd1, 1'b0, 8'h00};
    tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 3'd1, 1'b0, 8'h00};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 3'd1, 1'b0, 8'h00};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 3'd1, 1'b0, 8'h00};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 8'hA5, 3'd0, 1'b1, 8'h3C};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0, 8'hA5, 3'd0, 1'b0, 8'h3C};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h66, 1'b0, 8'hA5, 3'd0, 1'b0, 8'h3C};
    tbl[8] = '{1'b0, 1'b1, 8'h42, 1'b1, 8'h77, 1'b0, 8'hA5, 3'd1, 1'b0, 8'h3C};
    tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h42, 3'd1, 1'b0, 8'h3C};

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].rst, tbl[i].push, tbl[i].pd, tbl[i].ack, tbl[i].ad);
      tick();
      chk($sformatf("vec%0d.req", i),   client_req,      tbl[i].e_req);
      chk($sformatf("vec%0d.data", i),  client_data_req, tbl[i].e_data);
      chk($sformatf("vec%0d.count", i), count,           tbl[i].e_cnt);
      chk($sformatf("vec%0d.rsp_v", i), rsp_valid,       tbl[i].e_rv);
      chk($sformatf("vec%0d.rsp_d", i), rsp_data,        tbl[i].e_rd);
      chk($sformatf("vec%0d.ovf", i),   overflow,        1'b0);
      if (i == 0) chk("reset.state", dbg_state, 2'd0);
    end

    // fill and overflow
    drive(1, 0, 0, 0, 0); tick();
    for (int i = 1; i <= 5; i++) begin
      drive(0, 1, 8'(i), 0, 0);
      tick();
      if (i == 4) begin
        chk("fill.full", full, 1'b1);
        chk("fill.count", count, 3'd4);
        chk("fill.ovf_early", overflow, 1'b0);
      end
    end
    chk("fill.ovf", overflow, 1'b1);
    chk("fill.count5", count, 3'd4);
    chk("fill.data", client_data_req, 8'h01);
    chk("fill.req", client_req, 1'b1);

    // push on the ack edge while full
    drive(0, 1, 8'h77, 1, 8'h81); tick();
    chk("pushpop.count", count, 3'd4);
    chk("pushpop.ovf", overflow, 1'b1);
    chk("pushpop.rsp_v", rsp_valid, 1'b1);
    chk("pushpop.rsp_d", rsp_data, 8'h81);
    chk("pushpop.req", client_req, 1'b0);
    drive(0, 0, 0, 0, 0);

    // drain: FIFO order, gap length, payload stability, responses
    exp_q = '{8'h02, 8'h03, 8'h04, 8'h77};
    while (exp_q.size() > 0) begin
      low = 1; got_req = 0;
      for (int w = 0; w < 20; w++) begin
        tick();
        if (client_req) begin got_req = 1; break; end
        low++;
      end
      e = exp_q.pop_front();
      chk("order.rise", got_req, 1'b1);
      chk("order.gap", low, GAP + 1);
      chk("order.data", client_data_req, e);
      tick();
      chk("order.hold", client_data_req, e);
      drive(0, 0, 0, 1, e ^ 8'hFF); tick();
      chk("order.rsp_v", rsp_valid, 1'b1);
      chk("order.rsp_d", rsp_data, e ^ 8'hFF);
      drive(0, 0, 0, 0, 0);
    end
    chk("order.empty", count, 3'd0);
    chk("order.ovf_sticky", overflow, 1'b1);

    // reset mid-transfer with three entries queued
    drive(0, 1, 8'hC1, 0, 0); tick();
    drive(0, 1, 8'hC2, 0, 0); tick();
    drive(0, 1, 8'hC3, 0, 0); tick();
    chk("midrst.pre_req", client_req, 1'b1);
    chk("midrst.pre_count", count, 3'd3);
    drive(1, 1, 8'hEE, 1, 8'h99); tick();
    chk("midrst.req", client_req, 1'b0);
    chk("midrst.count", count, 3'd0);
    chk("midrst.ovf", overflow, 1'b0);
    chk("midrst.rsp_v", rsp_valid, 1'b0);
    chk("midrst.full", full, 1'b0);
    drive(0, 1, 8'h5A, 0, 0); tick();
    chk("midrst.push_count", count, 3'd1);
    chk("midrst.push_req", client_req, 1'b0);
    drive(0, 0, 0, 0, 0); tick();
    chk("midrst.issue_req", client_req, 1'b1);
    chk("midrst.issue_data", client_data_req, 8'h5A);

    // random traffic against the model
    drive(1, 0, 0, 0, 0); tick(); model_step(1, 0, 0, 0, 0);
    pp = 50;
    for (int c = 0; c < 1500; c++) begin
      if (c % 300 == 0) pp = $urandom_range(20, 75);
      r  = ($urandom_range(0, 199) == 0);
      p  = ($urandom_range(0, 99) < pp);
      pd = 8'($urandom);
      a  = ($urandom_range(0, 2) == 0);
      ad = 8'($urandom);
      drive(r, p, pd, a, ad);
      tick();
      model_step(r, p, pd, a, ad);
      chk($sformatf("rnd%0d.req", c),   client_req,      m_req);
      chk($sformatf("rnd%0d.data", c),  client_data_req, m_data);
      chk($sformatf("rnd%0d.count", c), count,           mq.size());
      chk($sformatf("rnd%0d.full", c),  full,            mq.size() == DEPTH);
      chk($sformatf("rnd%0d.ovf", c),   overflow,        m_ovf);
      chk($sformatf("rnd%0d.rsp_v", c), rsp_valid,       m_rv);
      chk($sformatf("rnd%0d.rsp_d", c), rsp_data,        m_rd);
    end

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
